// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU run/dump controller.
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_DUMP_REG = 3'd2,
    ST_DUMP_MEM = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam logic DUMP_KIND_REG = 1'b0;
  localparam logic DUMP_KIND_MEM = 1'b1;

  // Data memory is word-organised but addressed in bytes.
  localparam int BYTE_SHIFT = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dump_out_slot.sv
// Single-entry valid/ready holding register; payload is frozen while stalled.
module dump_out_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] in_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  // Next slot contents: a load always wins, otherwise an accepted beat empties it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/cpu_run_dump_ctrl.sv
// Runs the CPU for a programmed cycle budget, then streams register file and data memory.
// Optional early-exit on CPU halt: define CPU_HALT_DETECT_EN.
module cpu_run_dump_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int MEM_WORDS = 64,
  parameter int DATA_W    = 32,
  parameter int CYC_W     = 32,
  localparam int REG_AW   = (NUM_REGS  > 1) ? $clog2(NUM_REGS)  : 1,
  localparam int MEM_AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1,
  localparam int IDX_W    = max_int(REG_AW, MEM_AW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CYC_W-1:0]  cycle_budget,
  output logic              cpu_clk_en,
  output logic [REG_AW-1:0] dbg_reg_a,
  input  logic [DATA_W-1:0] dbg_reg_rd,
  output logic [31:0]       dbg_mem_a,
  input  logic [DATA_W-1:0] dbg_mem_rd,
`ifdef CPU_HALT_DETECT_EN
  input  logic              halt,
  output logic              halted,
`endif
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              dump_kind,
  output logic [IDX_W-1:0]  dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done,
  output logic [CYC_W-1:0]  cycles_run
);

  localparam int PAY_W = 1 + IDX_W + DATA_W;
  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(MEM_WORDS - 1);

  state_e             state_d, state_q;
  logic [CYC_W-1:0]   budget_d, budget_q;
  logic [CYC_W-1:0]   cycles_d, cycles_q;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic               load_s, halt_s, last_run_s, idle_s, kind_s;
  logic [DATA_W-1:0]  rd_data_s;
  logic [PAY_W-1:0]   pay_in_s, pay_out_s;

`ifdef CPU_HALT_DETECT_EN
  assign halt_s = halt;
`else
  assign halt_s = 1'b0;
`endif

  assign idle_s     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign load_s     = ((state_q == ST_DUMP_REG) || (state_q == ST_DUMP_MEM)) &&
                      (!dump_valid || dump_ready);
  assign last_run_s = (cycles_q == (budget_q - CYC_W'(1)));

  // Sequencing: run phase, then register dump, memory dump, drain of the last beat.
  always_comb begin
    state_d  = state_q;
    budget_d = budget_q;
    cycles_d = cycles_q;
    idx_d    = idx_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          budget_d = cycle_budget;
          cycles_d = {CYC_W{1'b0}};
          idx_d    = {IDX_W{1'b0}};
          state_d  = (cycle_budget == {CYC_W{1'b0}}) ? ST_DUMP_REG : ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        cycles_d = (cycles_q == {CYC_W{1'b1}}) ? cycles_q : cycles_q + CYC_W'(1);
        if (last_run_s || halt_s) begin
          state_d = ST_DUMP_REG;
          idx_d   = {IDX_W{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DUMP_REG: begin
        if (load_s && (idx_q == LAST_REG)) begin
          state_d = ST_DUMP_MEM;
          idx_d   = {IDX_W{1'b0}};
        end else if (load_s) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          idx_d = idx_q;
        end
      end
      ST_DUMP_MEM: begin
        if (load_s && (idx_q == LAST_MEM)) begin
          state_d = ST_DRAIN;
          idx_d   = {IDX_W{1'b0}};
        end else if (load_s) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          idx_d = idx_q;
        end
      end
      ST_DRAIN: begin
        if (dump_valid && dump_ready) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      budget_q <= {CYC_W{1'b0}};
      cycles_q <= {CYC_W{1'b0}};
      idx_q    <= {IDX_W{1'b0}};
    end else begin
      state_q  <= state_d;
      budget_q <= budget_d;
      cycles_q <= cycles_d;
      idx_q    <= idx_d;
    end
  end

  // Beat source: pick the debug read port matching the current dump phase.
  always_comb begin
    if (state_q == ST_DUMP_MEM) begin
      kind_s    = DUMP_KIND_MEM;
      rd_data_s = dbg_mem_rd;
    end else begin
      kind_s    = DUMP_KIND_REG;
      rd_data_s = dbg_reg_rd;
    end
  end

  // Debug addresses are parked at zero outside their own dump phase.
  always_comb begin
    dbg_reg_a = {REG_AW{1'b0}};
    dbg_mem_a = 32'd0;
    if (state_q == ST_DUMP_REG) begin
      dbg_reg_a = idx_q[REG_AW-1:0];
    end else if (state_q == ST_DUMP_MEM) begin
      dbg_mem_a = 32'(idx_q) << BYTE_SHIFT;
    end else begin
      dbg_reg_a = {REG_AW{1'b0}};
      dbg_mem_a = 32'd0;
    end
  end

  assign pay_in_s = {kind_s, idx_q, rd_data_s};

  dump_out_slot #(
    .W(PAY_W)
  ) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_s),
    .in_data (pay_in_s),
    .ready   (dump_ready),
    .valid   (dump_valid),
    .data    (pay_out_s)
  );

  assign {dump_kind, dump_index, dump_data} = pay_out_s;
  assign cpu_clk_en = (state_q == ST_RUN);
  assign busy       = !idle_s;
  assign done       = (state_q == ST_DONE);
  assign cycles_run = cycles_q;

`ifdef CPU_HALT_DETECT_EN
  logic halted_d, halted_q;

  // Sticky early-exit flag, cleared when the next run is launched.
  always_comb begin
    halted_d = halted_q;
    if (idle_s && start) begin
      halted_d = 1'b0;
    end else if ((state_q == ST_RUN) && halt) begin
      halted_d = 1'b1;
    end else begin
      halted_d = halted_q;
    end
  end

  // Halt flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`endif

endmodule

// File: doc/cpu_run_dump_ctrl.md
Name: cpu_run_dump_ctrl

Overview:
Hardware successor to the fixed-length run-then-dump bench sequence. It runs the single-cycle CPU for a programmable number of cycles by gating its clock enable. It then streams every register-file entry and every data-memory word out over a valid/ready port. Register count, memory depth and cycle-budget width are parametrised, and a run can be restarted without reset.

Parameters:
NUM_REGS, 32, register-file entries dumped; REG_AW = clog2(NUM_REGS)
MEM_WORDS, 64, data-memory words dumped; MEM_AW = clog2(MEM_WORDS)
DATA_W, 32, register and memory word width
CYC_W, 32, width of cycle budget and cycle counter

Ports:
clk  in  1  sole clock
rst_n  in  1  synchronous, active-low reset
start  in  1  launch a run; sampled only in IDLE or DONE
cycle_budget  in  CYC_W  CPU cycles to execute; sampled with start
cpu_clk_en  out  1  CPU/PC/memory advance enable
dbg_reg_a  out  REG_AW  register-file debug read address
dbg_reg_rd  in  DATA_W  combinational read data for dbg_reg_a
dbg_mem_a  out  32  data-memory byte address, always index*4
dbg_mem_rd  in  DATA_W  combinational read data for dbg_mem_a
dump_valid  out  1  dump beat available
dump_ready  in  1  consumer accepts beat
dump_kind  out  1  0 = register, 1 = memory
dump_index  out  max(REG_AW,MEM_AW)  register number or word index
dump_data  out  DATA_W  value
busy  out  1  state is not IDLE or DONE
done  out  1  high in DONE
cycles_run  out  CYC_W  CPU cycles executed in the current/last run

Behaviour:
- Reset (rst_n=0 at a clk edge) is synchronous and active-low. Every output goes to 0 and state goes to IDLE. This holds mid-run or mid-dump; an outstanding beat is dropped without handshake.
- States: IDLE, RUN, DUMP_REG, DUMP_MEM, DRAIN, DONE.
- IDLE/DONE: on start=1, latch cycle_budget and clear cycles_run.
  - Next state is RUN, or DUMP_REG directly if the budget is 0.
  - Starting from DONE does not reset CPU state; execution continues from the current PC.
- RUN:
  - cpu_clk_en=1 combinationally in every RUN cycle; cycles_run increments each RUN cycle.
  - When cycles_run == budget-1, this is the last enabled cycle; next state is DUMP_REG.
  - The CPU therefore advances exactly budget edges.
- cpu_clk_en=0 in all other states.
- start is ignored while busy.
- Output register, one slot:
  - Load condition: state is DUMP_REG or DUMP_MEM, and (!dump_valid || dump_ready).
  - On load, capture the current index, kind and rd data, set dump_valid=1, and increment index.
  - dump_kind, dump_index and dump_data are stable while dump_valid && !dump_ready.
  - dump_valid falls only after acceptance with no new load.
- Throughput and latency:
  - Throughput is 1 beat/clk while dump_ready=1.
  - The first beat is valid the cycle after entering DUMP_REG.
- Address and state sequencing:
  - dbg_reg_a is the register index in DUMP_REG; dbg_mem_a = mem index << 2 in DUMP_MEM; both are 0 otherwise.
  - After loading register NUM_REGS-1: go to DUMP_MEM with index 0.
  - After loading word MEM_WORDS-1: go to DRAIN.
- DRAIN: on dump_valid && dump_ready, clear dump_valid and go to DONE.
- Index counters wrap only via explicit reset to 0 on a state change, never by overflow.
- cycles_run saturates at all-ones; with CYC_W ≥ budget width it cannot overflow.

Optional Feature:
CPU_HALT_DETECT_EN
- Defined:
  - Adds input halt (1 bit).
  - halt=1 in RUN ends the run after the current enabled cycle, even if the budget remains; next state is DUMP_REG.
  - cycles_run includes that cycle.
  - Adds output halted (1 bit): set on early exit, cleared on start.
- Undefined: no halt or halted port; the run always consumes the full budget.

Decomposition:
- Package cpu_dbg_pkg holds:
  - state enum;
  - DUMP_KIND_REG/DUMP_KIND_MEM constants;
  - the byte-per-word shift constant (2).
- One sub-module, dump_out_slot: the single-entry valid/ready holding register, parametrised on payload width.

Test Plan:
- Budget 0: start with cycle_budget=0 -> cpu_clk_en never high, cycles_run=0, 32 register beats then 64 memory beats, done=1.
- Run then dump: program "addi $1,$0,5; sw $1,8($0)", budget=2, dump_ready=1 -> cpu_clk_en high exactly 2 cycles. Register beat 1 = 5; memory beat index 2, dbg_mem_a=8, value 5; 96 beats in 96 consecutive cycles.
- Backpressure: dump_ready random 30% -> no beat lost or duplicated, indices strictly ascending per kind, data stable while stalled.
- Reset during DUMP_MEM at index 10 -> next edge dump_valid=0, busy=0, state IDLE, cpu_clk_en=0.
- Restart from DONE: budget 3 then budget 4 -> cycles_run 3 then 4; second dump reflects 7 total instructions executed.
- CPU_HALT_DETECT_EN: budget 100, halt asserted in the 6th RUN cycle -> cycles_run=6, halted=1, dump follows.
